// File: rtl/pupil_centroid.sv
// pupil_centroid -- centroid of the dark (target) pixels in a binarized video
// stream. Each frame's pixel count and coordinate sums are accumulated on the
// fly. At the next frame boundary these values are handed to a serial restoring
// divider, which produces center_x and center_y.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bin_vsync           frame sync; its rising edge is the frame boundary (FB)
//   bin_hsync           line sync, high during the active line
//   bin_data_valid      pixel qualifier
//   bin_data_in         binarized pixel (8'h00 / 8'hFF)
//   result_valid        one-cycle pulse when new results are presented
//   target_found        count >= MIN_PIX for the reported frame
//   center_x/center_y   floor(sum / count), 0 when no target was found
//   pixel_count         target pixel count of the reported frame
//   overrun             one-cycle pulse when a frame result had to be dropped
module pupil_centroid #(
    parameter int          IMG_W   = 640,
    parameter int          IMG_H   = 480,
    parameter int          XW      = 10,
    parameter int          YW      = 10,
    parameter int          CW      = 20,
    parameter int          SW      = 30,
    parameter logic [7:0]  FG_VAL  = 8'h00,
    parameter int          MIN_PIX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bin_vsync,
    input  logic          bin_hsync,
    input  logic          bin_data_valid,
    input  logic [7:0]    bin_data_in,
    output logic          result_valid,
    output logic          target_found,
    output logic [XW-1:0] center_x,
    output logic [YW-1:0] center_y,
    output logic [CW-1:0] pixel_count,
    output logic          overrun
);

    localparam int IW = $clog2(SW + 1);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    // ---------------- front end: sync edges, coordinates, accumulators ----
    logic          vs_q, hs_q, line_seen;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] count;
    logic [SW-1:0] sum_x, sum_y;

    logic fb, hs_fall, qual;
    assign fb      = bin_vsync & ~vs_q;
    assign hs_fall = ~bin_hsync & hs_q;
    // The extra leading zero keeps the bound compare valid when IMG_W/IMG_H
    // equal 2**XW / 2**YW.
    assign qual = bin_data_valid && (bin_data_in == FG_VAL) &&
                  ({1'b0, x} < (XW+1)'(IMG_W)) && ({1'b0, y} < (YW+1)'(IMG_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            line_seen <= 1'b0;
            x         <= '0;
            y         <= '0;
            count     <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
        end else begin
            vs_q <= bin_vsync;
            hs_q <= bin_hsync;

            if (fb || hs_fall)
                x <= '0;
            else if (bin_data_valid)
                x <= x + 1'b1;

            // Blank lines (no valid pixels) do not advance y.
            if (fb) begin
                y         <= '0;
                line_seen <= 1'b0;
            end else if (hs_fall) begin
                if (line_seen) y <= y + 1'b1;
                line_seen <= 1'b0;
            end else if (bin_data_valid) begin
                line_seen <= 1'b1;
            end

            // A qualifying pixel in the FB cycle opens the new frame's totals.
            if (fb) begin
                count <= qual ? CW'(1) : '0;
                sum_x <= qual ? SW'(x) : '0;
                sum_y <= qual ? SW'(y) : '0;
            end else if (qual) begin
                count <= count + 1'b1;
                sum_x <= sum_x + SW'(x);
                sum_y <= sum_y + SW'(y);
            end
        end
    end

    // ---------------- restoring divider step -----------------------------
    // The dividend register shifts its MSB into the remainder and takes the
    // new quotient bit at its LSB. After SW steps it therefore holds the
    // quotient.
    logic [CW-1:0] div_rem, divisor;
    logic [SW-1:0] div_dvd, snap_sum_y;
    logic [CW:0]   rem_sh, diff;
    logic          q_bit;
    logic [CW-1:0] rem_nxt;
    logic [SW-1:0] q_nxt;

    assign rem_sh  = {div_rem, div_dvd[SW-1]};
    assign diff    = rem_sh - {1'b0, divisor};
    assign q_bit   = ~diff[CW];                 // no borrow -> rem_sh >= divisor
    assign rem_nxt = q_bit ? diff[CW-1:0] : rem_sh[CW-1:0];
    assign q_nxt   = {div_dvd[SW-2:0], q_bit};

    // ---------------- control FSM with registered outputs ----------------
    state_t        state;
    logic [IW-1:0] it;
    logic          frame_active, found_r;
    logic [CW-1:0] count_r;
    logic [XW-1:0] qx;
    logic [YW-1:0] qy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            it           <= '0;
            frame_active <= 1'b0;
            found_r      <= 1'b0;
            count_r      <= '0;
            qx           <= '0;
            qy           <= '0;
            div_rem      <= '0;
            divisor      <= '0;
            div_dvd      <= '0;
            snap_sum_y   <= '0;
            result_valid <= 1'b0;
            target_found <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            pixel_count  <= '0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            if (fb) frame_active <= 1'b1;

            // A busy divider keeps its job; the new frame's totals are lost.
            if (fb && frame_active && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (fb && frame_active) begin
                        count_r <= count;
                        if (count >= CW'(MIN_PIX)) begin
                            found_r    <= 1'b1;
                            divisor    <= count;
                            div_dvd    <= sum_x;
                            snap_sum_y <= sum_y;
                            div_rem    <= '0;
                            it         <= '0;
                            state      <= DIV_X;
                        end else begin
                            found_r <= 1'b0;
                            qx      <= '0;
                            qy      <= '0;
                            state   <= DONE;
                        end
                    end
                end
                DIV_X: begin
                    div_rem <= rem_nxt;
                    div_dvd <= q_nxt;
                    it      <= it + 1'b1;
                    if (it == IW'(SW - 1)) begin
                        qx      <= q_nxt[XW-1:0];
                        div_rem <= '0;
                        div_dvd <= snap_sum_y;
                        it      <= '0;
                        state   <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    div_rem <= rem_nxt;
                    div_dvd <= q_nxt;
                    it      <= it + 1'b1;
                    if (it == IW'(SW - 1)) begin
                        qy    <= q_nxt[YW-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b1;
                    target_found <= found_r;
                    center_x     <= qx;
                    center_y     <= qy;
                    pixel_count  <= count_r;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_centroid.sv
module tb_pupil_centroid;

    localparam int IMG_W = 16;
    localparam int IMG_H = 24;
    localparam int XW = 10, YW = 10, CW = 20, SW = 30;
    localparam int LAT_FOUND = 2 * SW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0, hsync = 1'b0, dvalid = 1'b0;
    logic [7:0]    din = 8'hFF;
    logic          result_valid, target_found, overrun;
    logic [XW-1:0] center_x;
    logic [YW-1:0] center_y;
    logic [CW-1:0] pixel_count;

    pupil_centroid #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .CW(CW), .SW(SW),
        .FG_VAL(8'h00), .MIN_PIX(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bin_vsync(vsync), .bin_hsync(hsync),
        .bin_data_valid(dvalid), .bin_data_in(din),
        .result_valid(result_valid), .target_found(target_found),
        .center_x(center_x), .center_y(center_y),
        .pixel_count(pixel_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int res_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame stimulus (w x h raster, dark rectangle) with its expected result.
    typedef struct {
        int w, h, x0, x1, y0, y1;
        int found, cx, cy, cnt;
    } vec_t;

    typedef struct {
        int found, cx, cy, cnt, due;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every result_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (result_valid) begin
            res_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency_cycle", cyc, e.due);
                chk("target_found", int'(target_found), e.found);
                chk("center_x", int'(center_x), e.cx);
                chk("center_y", int'(center_y), e.cy);
                chk("pixel_count", int'(pixel_count), e.cnt);
                last = e;
            end
        end
    end

    task automatic send_frame(input vec_t v);
        for (int yy = 0; yy < v.h; yy++) begin
            @(negedge clk); hsync = 1'b1;
            for (int xx = 0; xx < v.w; xx++) begin
                @(negedge clk);
                dvalid = 1'b1;
                din = (xx >= v.x0 && xx <= v.x1 && yy >= v.y0 && yy <= v.y1) ? 8'h00 : 8'hFF;
            end
            @(negedge clk); dvalid = 1'b0; din = 8'hFF; hsync = 1'b0;
            @(negedge clk);
        end
    endtask

    // Raise vsync; optionally queue the result the boundary should produce.
    task automatic fire_fb(input bit push, input vec_t v);
        exp_t e;
        @(negedge clk);
        vsync = 1'b1;
        if (push) begin
            e.found = v.found;
            e.cx = v.found ? v.cx : 0;
            e.cy = v.found ? v.cy : 0;
            e.cnt = v.cnt;
            e.due = cyc + 1 + (v.found ? LAT_FOUND : 1);
            sb.push_back(e);
        end
        @(negedge clk);
        @(negedge clk); vsync = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_target_found"}, int'(target_found), 0);
        chk({tag, "_center_x"}, int'(center_x), 0);
        chk({tag, "_center_y"}, int'(center_y), 0);
        chk({tag, "_pixel_count"}, int'(pixel_count), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    vec_t tbl[7];
    vec_t none_v;

    initial begin
        //            w   h   x0  x1  y0  y1  found cx  cy  cnt
        tbl[0] = '{  8,  5,   5,  5,  3,  3,  1,    5,  3,  1 };
        tbl[1] = '{ 13, 23,  10, 11, 20, 21,  1,   10, 20,  4 };
        tbl[2] = '{  8,  4,   1,  0,  0,  0,  0,    0,  0,  0 };
        tbl[3] = '{ 17, 25,  14, 16, 22, 24,  1,   14, 22,  4 };
        tbl[4] = '{ 12,  8,   3,  9,  1,  6,  1,    6,  3, 42 };
        tbl[5] = '{ 16, 24,  15, 15,  0, 23,  1,   15, 11, 24 };
        tbl[6] = '{ 17,  4,  16, 16,  0,  3,  0,    0,  0,  0 };
        none_v = tbl[2];
        last = '{0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // First boundary after reset has no preceding frame: nothing expected.
        send_frame(tbl[0]);
        fire_fb(1'b0, none_v);
        repeat (70) @(negedge clk);
        chk("first_fb_no_result", res_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i]);
            chk($sformatf("hold_found_%0d", i), int'(target_found), last.found);
            chk($sformatf("hold_cx_%0d", i), int'(center_x), last.cx);
            chk($sformatf("hold_cnt_%0d", i), int'(pixel_count), last.cnt);
            fire_fb(1'b1, tbl[i]);
            drain($sformatf("drain_vec_%0d", i));
        end
        chk("no_overrun_yet", ovr_cnt, 0);

        // Second boundary 10 cycles after the first lands mid-division.
        send_frame(tbl[4]);
        @(negedge clk);
        vsync = 1'b1;
        sb.push_back('{1, 6, 3, 42, cyc + 1 + LAT_FOUND});
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (8) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        drain("drain_overrun");
        chk("overrun_pulses", ovr_cnt, 1);
        send_frame(tbl[1]);
        fire_fb(1'b1, tbl[1]);
        drain("drain_after_overrun");

        // Reset five cycles into the x division aborts it.
        send_frame(tbl[4]);
        fire_fb(1'b0, none_v);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("midreset_no_result", int'(target_found) + int'(pixel_count), 0);
        send_frame(tbl[0]);
        fire_fb(1'b0, none_v);
        repeat (70) @(negedge clk);
        chk("post_reset_first_fb_zero", int'(pixel_count), 0);
        send_frame(tbl[3]);
        fire_fb(1'b1, tbl[3]);
        drain("drain_post_reset");
        chk("final_overrun_total", ovr_cnt, 1);
        chk("final_result_total", res_cnt, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pupil_centroid.md
PUPIL_CENTROID -- requirements
Module: pupil_centroid

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line; pixels with x >= IMG_W are ignored.
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame; pixels with y >= IMG_H are ignored.
REQ-003 SHALL have parameter XW, default 10, width of the x counter and center_x.
REQ-004 SHALL have parameter YW, default 10, width of the y counter and center_y.
REQ-005 SHALL have parameter CW, default 20, width of the pixel-count accumulator.
REQ-006 SHALL have parameter SW, default 30, width of the sum accumulators and the number of divider iterations.
REQ-007 SHALL have parameter FG_VAL, default 8'h00, the pixel value counted as target (dark pupil).
REQ-008 SHALL have parameter MIN_PIX, default 16, the minimum target count for a valid detection.
REQ-009 SHALL have ports, each listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst_n, in, 1, reset (asynchronous, active-low).
- bin_vsync, in, 1, frame sync, active-high; its rising edge marks a frame boundary.
- bin_hsync, in, 1, line sync, high during the active line.
- bin_data_valid, in, 1, pixel qualifier.
- bin_data_in, in, 8, binarized pixel, 8'h00 or 8'hFF.
- result_valid, out, 1, single-cycle pulse when a new result is available.
- target_found, out, 1, 1 when count >= MIN_PIX.
- center_x, out, XW, floor of sum_x / count.
- center_y, out, YW, floor of sum_y / count.
- pixel_count, out, CW, target pixel count of the frame.
- overrun, out, 1, single-cycle pulse when a frame result is dropped.

Function
REQ-010 SHALL register bin_vsync and bin_hsync (reset 0) for edge detection; a frame boundary (FB) is a cycle with bin_vsync=1 and previous vsync=0.
REQ-011 SHALL increment x on each cycle with bin_data_valid=1, and reset x to 0 on an hsync falling edge and at FB.
REQ-012 SHALL increment y on an hsync falling edge only if the line had at least one valid pixel, and reset y to 0 at FB.
REQ-013 SHALL accumulate count+=1, sum_x+=x and sum_y+=y on cycles with valid=1, data==FG_VAL, x<IMG_W and y<IMG_H.
REQ-014 At FB, SHALL snapshot count/sum_x/sum_y into the divider, then clear the accumulators; a qualifying pixel in the FB cycle SHALL be counted in the new frame.
REQ-015 SHALL produce no result and no overrun at the first FB after reset, since no complete frame precedes it; a frame_active flag gates this.
REQ-016 SHALL use FSM states IDLE, DIV_X, DIV_Y and DONE.
- IDLE to DIV_X at FB when frame_active=1 and snapshot count >= MIN_PIX.
- IDLE to DONE at FB when frame_active=1 and count < MIN_PIX; target_found=0 and centers=0 in this case.
- DIV_X to DIV_Y after SW cycles.
- DIV_Y to DONE after SW cycles.
- DONE to IDLE after 1 cycle.
REQ-017 SHALL perform the division as a restoring divide, one quotient bit per cycle, MSB first; the quotient is truncated to XW/YW bits (always in range by construction).
REQ-018 SHALL update result_valid=1 and all outputs together on DONE entry; result_valid SHALL be high exactly 1 cycle.
- Found case: outputs update at edge 2*SW+1, counting the FB edge as 0.
- Not-found case: outputs update at edge 1.
REQ-019 SHALL hold center_x, center_y, pixel_count and target_found stable between results.
REQ-020 On FB while FSM != IDLE, SHALL drop the new snapshot, pulse overrun for 1 cycle and let the in-progress division complete unchanged; accumulators are still cleared.
REQ-021 SHALL never wrap the accumulators, given the default widths and the REQ-013 bounds.

Reset
REQ-022 While rst_n=0, SHALL clear all outputs, counters, accumulators, the divider, frame_active and the edge registers to 0, and set the FSM to IDLE.
REQ-023 Reset asserted mid-division SHALL abort the division with no result_valid; the next FB after release is treated as the first.

Verification
REQ-024 With MIN_PIX=1, a single 8'h00 pixel at (5,3) in frame 2, then FB -> result_valid after edge 61; center_x=5, center_y=3, pixel_count=1, target_found=1.
REQ-025 A 2x2 dark block at x=10..11, y=20..21, then FB -> pixel_count=4, center_x=10 (42/4 floored), center_y=20 (82/4 floored), target_found=1.
REQ-026 An all-8'hFF frame, then FB -> result_valid after edge 1; target_found=0, center_x=0, center_y=0, pixel_count=0.
REQ-027 Two FBs 10 cycles apart -> overrun pulses once; exactly one result_valid from the first frame, with correct values.
REQ-028 rst_n low at DIV_X cycle 5 -> all outputs 0, no result_valid; the first FB after release yields no result; the following frame yields a correct result.
REQ-029 Dark pixels at x=IMG_W and at y=IMG_H -> not counted; pixel_count is unchanged by them.
